// File: rtl/spi_listener_pkg.sv
// spi_listener_pkg
//   Shared definitions for the SPI command listener and the process
//   controller that consumes its words: default frame length, FSM state
//   encoding, bit-counter width and the command opcodes carried in
//   fpga_spi_data[23:16].
package spi_listener_pkg;

  localparam int DATA_BITS_DEF = 24;

  // Wide enough for DATA_BITS+1 at the largest legal frame length (33).
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_e;

  // Command opcodes, fpga_spi_data[23:16].
  localparam logic [7:0] OP_AMP_CTRL = 8'h00;
  // Payload bit of OP_AMP_CTRL that enables the amplifier.
  localparam int         AMP_EN_BIT  = 1;

  // Increment that sticks at lim, so overlong frames stay distinguishable
  // from exact-length ones without the counter wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/spi_listener_if.sv
// spi_listener_if
//   The SPI pin bundle between the host MCU and the listener.
//   master : host side, drives sclk/cs_n/mosi, observes miso/miso_oe
//   slave  : listener side, observes sclk/cs_n/mosi, drives miso/miso_oe
interface spi_listener_if;

  logic spi_sclk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (
    output spi_sclk,
    output spi_cs_n,
    output spi_mosi,
    input  spi_miso,
    input  spi_miso_oe
  );

  modport slave (
    input  spi_sclk,
    input  spi_cs_n,
    input  spi_mosi,
    output spi_miso,
    output spi_miso_oe
  );

endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
//   N-stage synchroniser for one asynchronous pin, with single-cycle
//   rise/fall pulses derived from the synchronised level.
//   clk, rst_n : system clock, async active-low reset
//   async_i    : asynchronous input pin
//   level_o    : synchronised level (last flop of the chain)
//   rise_o     : one-cycle pulse on a 0->1 transition of level_o
//   fall_o     : one-cycle pulse on a 1->0 transition of level_o
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  // The delay flop is preset to the same value as the chain so that
  // reset release itself never produces an edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      dly_q  <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~dly_q;
  assign fall_o  = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/spi_listener.sv
// spi_listener
//   SPI mode-0 responder. Receives fixed-length MSB-first command words
//   from the host, presents each complete word on fpga_spi_data with a
//   one-cycle interrupt, and shifts tx_data back on MISO in the same frame.
//   All SPI pins are oversampled on clk (clk >= 4x sclk).
//
//   clk, rst_n             : system clock, async active-low reset
//   spi                    : SPI pins (slave modport)
//   tx_data                : readback word, captured when cs_n falls
//   fpga_spi_data          : last correctly framed word
//   spi_listener_interrupt : 1-cycle pulse, fpga_spi_data valid that cycle
//   frame_error            : 1-cycle pulse on a short or overlong frame
//   busy                   : high while a frame is in progress
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   WAIT_IDLE | after reset; wait for cs_n settled high, drop any frame
//   IDLE      | deselected, waiting for cs_n to fall
//   ACTIVE    | selected; shift mosi in on sclk rise, miso out on fall
module spi_listener
  import spi_listener_pkg::*;
#(
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_listener_if.slave        spi,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic [DATA_BITS-1:0] fpga_spi_data,
  output logic                 spi_listener_interrupt,
  output logic                 frame_error,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SYNC_STAGES);

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (spi.spi_sclk),
    .level_o (sclk_lvl_unused),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (spi.spi_cs_n),
    .level_o (cs_lvl),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  // Same depth as sclk, so the mosi level seen on an sclk_rise is the
  // value that was on the pin at the sclk pin edge.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (spi.spi_mosi),
    .level_o (mosi_lvl),
    .rise_o  (mosi_rise_unused),
    .fall_o  (mosi_fall_unused)
  );

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] rx_q, rx_d;
  logic [DATA_BITS-1:0] tx_q, tx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 miso_q, miso_d;
  logic                 oe_q, oe_d;
  logic                 irq_q, irq_d;
  logic                 err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      data_q  <= '0;
      miso_q  <= 1'b0;
      oe_q    <= 1'b0;
      irq_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      data_q  <= data_d;
      miso_q  <= miso_d;
      oe_q    <= oe_d;
      irq_q   <= irq_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    data_d  = data_q;
    miso_d  = miso_q;
    oe_d    = oe_q;
    irq_d   = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      // The synchroniser chain is preset to cs_n=1, so the first
      // SYNC_STAGES samples after reset say nothing about the pin. The
      // bit counter doubles as a settle counter here: cs_n must read high
      // for SYNC_STAGES+1 consecutive cycles, the last of which reflects
      // the real pin, before a frame can be recognised.
      WAIT_IDLE: begin
        if (!cs_lvl) begin
          cnt_d = '0;
        end else if (cnt_q >= CNT_SETTLE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      IDLE: begin
        if (cs_fall) begin
          tx_d    = tx_data;
          miso_d  = tx_data[DATA_BITS-1];
          oe_d    = 1'b1;
          cnt_d   = '0;
          rx_d    = '0;
          state_d = ACTIVE;
        end
      end

      ACTIVE: begin
        // cs_rise wins over any sclk edge in the same cycle.
        if (cs_rise) begin
          state_d = IDLE;
          oe_d    = 1'b0;
          miso_d  = 1'b0;
          if (cnt_q == CNT_FULL) begin
            data_d = rx_q;
            irq_d  = 1'b1;
          end else if (cnt_q != '0) begin
            err_d = 1'b1;
          end
        end else if (sclk_rise) begin
          rx_d  = {rx_q[DATA_BITS-2:0], mosi_lvl};
          cnt_d = sat_inc(cnt_q, CNT_SAT);
        end else if (sclk_fall) begin
          if (cnt_q < CNT_FULL) begin
            tx_d   = {tx_q[DATA_BITS-2:0], 1'b0};
            miso_d = tx_q[DATA_BITS-2];
          end else begin
            miso_d = 1'b0;
          end
        end
      end

      default: state_d = WAIT_IDLE;
    endcase
  end

  assign spi.spi_miso           = miso_q;
  assign spi.spi_miso_oe        = oe_q;
  assign busy                   = oe_q;
  assign fpga_spi_data          = data_q;
  assign spi_listener_interrupt = irq_q;
  assign frame_error            = err_q;

endmodule
